ram_s2p_fifo_ctrl: RTL and testbench

- Valid/ready synchronous FIFO controller that wraps the team's simple dual-port byte-enable RAM.
- Drives the RAM write port (A) from an upstream stream.
- Drives the RAM read address (B) and consumes its 1-cycle registered read data.
- Presents a registered, first-word-fall-through stream downstream, with a 2-entry output buffer that hides the RAM read latency.
- Full throughput: 1 word/cycle in and out.

---
 rtl/ram_s2p_fifo_ctrl.sv | 138 +++++++++++++
 tb/tb_ram_s2p_fifo_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_s2p_fifo_ctrl.sv
// Valid/ready FIFO controller around a simple dual-port RAM with a 1-cycle
// registered read port. Words are written through RAM port A, read back through
// port B, and staged in a 2-entry output buffer so that the downstream side sees
// a registered, first-word-fall-through stream at one word per cycle.
module ram_s2p_fifo_ctrl #(
  parameter int BYTE_WIDTH    = 8,
  parameter int BYTES_IN_WORD = 4,
  parameter int WORD_COUNT    = 256,
  localparam int ADDR_WIDTH   = $clog2(WORD_COUNT),
  localparam int WORD_WIDTH   = BYTE_WIDTH * BYTES_IN_WORD,
  localparam int CNT_WIDTH    = $clog2(WORD_COUNT + 3)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [WORD_WIDTH-1:0]    s_data_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [WORD_WIDTH-1:0]    m_data_o,
  output logic                     ram_we_o,
  output logic [BYTES_IN_WORD-1:0] ram_be_o,
  output logic [ADDR_WIDTH-1:0]    ram_waddr_o,
  output logic [WORD_WIDTH-1:0]    ram_wdata_o,
  output logic [ADDR_WIDTH-1:0]    ram_raddr_o,
  input  logic [WORD_WIDTH-1:0]    ram_rdata_i,
  output logic [CNT_WIDTH-1:0]     count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PTR_WIDTH = ADDR_WIDTH + 1;

  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [WORD_WIDTH-1:0] buf0_q, buf0_d;
  logic [WORD_WIDTH-1:0] buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic [PTR_WIDTH-1:0]  ram_occ;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [1:0]            buf_after_pop;
  logic [1:0]            stage_after_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign ram_occ = wr_ptr_q - rd_ptr_q;
  assign full    = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

  assign s_ready_o = !full && !rst_i;
  assign push      = s_valid_i && s_ready_o;
  assign m_valid_o = (buf_cnt_q != 2'd0);
  assign m_data_o  = buf0_q;
  assign pop       = m_valid_o && m_ready_i;

  // A read is issued only while the staged words (buffer + in-flight) that
  // survive this edge leave room for one more. Counting the pop here keeps the
  // buffer topped up at full rate; without it the output would bubble every
  // other word. Occupancy uses pre-edge pointers, so the slot being written
  // this cycle is never the one being read.
  assign buf_after_pop   = buf_cnt_q - {1'b0, pop};
  assign stage_after_pop = buf_after_pop + {1'b0, inflight_q};
  assign issue           = (ram_occ != '0) && (stage_after_pop < 2'd2);

  assign ram_we_o    = push;
  assign ram_be_o    = '1;
  assign ram_waddr_o = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_wdata_o = s_data_i;
  assign ram_raddr_o = rd_ptr_q[ADDR_WIDTH-1:0];

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = full;

  // Next-state for pointers, the output buffer and the occupancy counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = issue;
    buf_cnt_d  = stage_after_pop;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    count_d    = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    end

    // Popping with two words buffered shifts the second into the head.
    if (pop && (buf_cnt_q == 2'd2)) begin
      buf0_d = buf1_q;
    end
    // Returning read data lands in the first free slot after the pop.
    if (inflight_q) begin
      if (buf_after_pop == 2'd0) begin
        buf0_d = ram_rdata_i;
      end else begin
        buf1_d = ram_rdata_i;
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards stored words and any read in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_ram_s2p_fifo_ctrl.sv
// Bench for ram_s2p_fifo_ctrl with an 8-word RAM attached. The reference is a
// queue of accepted words, each stamped with the edge at which it was accepted;
// the head is visible downstream once two edges have passed since its push.
module tb_ram_s2p_fifo_ctrl;

  localparam int W  = 8;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [CW-1:0] count;
  logic          empty, full;

  always #5 clk = ~clk;

  ram_s2p_fifo_ctrl #(
    .BYTE_WIDTH   (8),
    .BYTES_IN_WORD(4),
    .WORD_COUNT   (W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .s_data_i   (s_data),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_data_o   (m_data),
    .ram_we_o   (ram_we),
    .ram_be_o   (ram_be),
    .ram_waddr_o(ram_waddr),
    .ram_wdata_o(ram_wdata),
    .ram_raddr_o(ram_raddr),
    .ram_rdata_i(ram_rdata),
    .count_o    (count),
    .empty_o    (empty),
    .full_o     (full)
  );

  // Simple dual-port RAM: registered read, old data on same-edge collision.
  logic [DW-1:0] mem [W];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } ent_t;

  ent_t          q[$];
  int            cyc;
  int            wr_cnt;
  int            accepted;
  int            errors;
  int            checks;
  logic          hold_prev;
  logic [DW-1:0] hold_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check pre-edge outputs at the falling edge,
  // then advance the reference across the rising edge.
  task automatic step(input logic r, input logic sv, input logic [DW-1:0] sd, input logic mr);
    logic exp_valid;
    logic push;
    logic pop;
    rst = r; s_valid = sv; s_data = sd; m_ready = mr;
    @(negedge clk);
    exp_valid = (q.size() > 0) && ((cyc - q[0].t) >= 2);
    chk("m_valid", m_valid, exp_valid);
    if (exp_valid) chk("m_data", m_data, q[0].d);
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    if (hold_prev) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, hold_data);
    end
    push = sv && s_ready && !r;
    pop  = exp_valid && mr && !r;
    if (r) begin
      chk("rst_ready", s_ready, 0);
      chk("rst_we", ram_we, 0);
    end else begin
      if (q.size() == W + 2) chk("cap_ready", s_ready, 0);
      chk("we", ram_we, sv && s_ready);
      if (push) begin
        chk("waddr", ram_waddr, wr_cnt % W);
        chk("wdata", ram_wdata, sd);
      end
    end
    hold_prev = !r && m_valid && !mr;
    hold_data = m_data;
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
      wr_cnt = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{d: sd, t: cyc});
        wr_cnt++;
        accepted++;
      end
    end
    #1;
  endtask

  initial begin
    int run;
    int best;
    int iter;
    logic sv;
    logic mr;

    errors = 0; checks = 0; cyc = 0; wr_cnt = 0; accepted = 0;
    hold_prev = 1'b0; hold_data = '0;
    rst = 1'b1; s_valid = 1'b1; s_data = 32'h1234_5678; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset state (rst still high)
    chk("rst_m_valid", m_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_raddr", ram_raddr, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("ram_be", ram_be, 4'hF);

    // single word: visible two edges after acceptance
    step(0, 1, 32'hA5A5_0001, 1);
    step(0, 0, 0, 1);
    chk("lat_n1_valid", m_valid, 0);
    step(0, 0, 0, 1);
    chk("lat_n2_valid", m_valid, 1);
    chk("lat_n2_data", m_data, 32'hA5A5_0001);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("single_count", count, 0);
    chk("single_empty", empty, 1);

    // fill with downstream stalled
    accepted = 0;
    for (int i = 1; i <= 12; i++) step(0, 1, i, 0);
    chk("fill_accepted", accepted, 10);
    chk("fill_full", full, 1);
    chk("fill_ready", s_ready, 0);
    chk("fill_count", count, 10);
    chk("fill_head", m_data, 1);
    step(0, 0, 0, 1);
    chk("fill_ready_rise", s_ready, 1);
    chk("fill_full_drop", full, 0);
    repeat (14) step(0, 0, 0, 1);
    chk("fill_drain_count", count, 0);
    chk("fill_drain_empty", empty, 1);

    // streaming: 100 words, no bubbles
    accepted = 0; run = 0; best = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 1, i, 1);
      if (m_valid) run++; else run = 0;
      if (run > best) best = run;
    end
    repeat (5) begin
      step(0, 0, 0, 1);
      if (m_valid) run++; else run = 0;
      if (run > best) best = run;
    end
    chk("stream_accepted", accepted, 100);
    chk("stream_run", best, 100);
    chk("stream_count", count, 0);

    // random valid/ready, 1000 words
    accepted = 0; iter = 0;
    while (accepted < 1000 && iter < 20000) begin
      step(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      iter++;
    end
    chk("rand_accepted", accepted, 1000);
    repeat (15) step(0, 0, 0, 1);
    chk("rand_drain_count", count, 0);

    // wrap: occupancy kept within 3..7, never full
    accepted = 0; iter = 0;
    while (accepted < 3 * W + 5 && iter < 2000) begin
      sv = (q.size() < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      mr = (q.size() > 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(0, sv, $urandom, mr);
      chk("wrap_full", full, 0);
      iter++;
    end
    chk("wrap_accepted", accepted, 3 * W + 5);
    repeat (12) step(0, 0, 0, 1);
    chk("wrap_drain_count", count, 0);

    // reset with words stored and a read in flight
    for (int i = 0; i < 6; i++) step(0, 1, 32'h100 + i, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("pre_rst_count", count, 5);
    step(1, 1, 32'h55, 1);
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    #1;
    chk("post_rst_valid", m_valid, 0);
    chk("post_rst_count", count, 0);
    chk("post_rst_ready", s_ready, 1);
    chk("post_rst_data", m_data, 0);
    step(0, 1, 32'hDEAD, 1);
    step(0, 0, 0, 1);
    chk("dead_early", m_valid, 0);
    step(0, 0, 0, 1);
    chk("dead_valid", m_valid, 1);
    chk("dead_data", m_data, 32'hDEAD);
    repeat (5) step(0, 0, 0, 1);
    chk("dead_count", count, 0);
    chk("dead_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
